// File: rtl/sw_conditioner.sv
// Multi-channel board-input conditioner: per-channel synchroniser, debounce and edge
// pulses, plus a reset-sequencing FSM that stretches the system reset from one channel.
module sw_conditioner #(
  parameter int CHANNELS        = 10,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_CHANNEL     = 0,
  parameter int RST_STRETCH     = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CHANNELS-1:0] raw_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                main_rst_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(RST_STRETCH + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW-1:0] STR_LAST = SW'(RST_STRETCH - 1);
  localparam logic [SW-1:0] STR_ONE  = SW'(1);

  localparam logic [1:0] S_RESET   = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  sync_last;
  logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;
  logic [1:0]                           state_q, state_d;
  logic [SW-1:0]                        str_q, str_d;
  logic                                 main_rst_q, main_rst_d;
  logic                                 src;

  // Synchroniser shift chains; the oldest stage is the value the debouncer sees.
  always_comb begin
    sync_d    = '0;
    sync_last = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], raw_i[i]};
      sync_last[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Debounce: a disagreement must persist DEBOUNCE_CYCLES edges before the level flips.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync_last[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        level_d[i] = sync_last[i];
        rise_d[i]  = sync_last[i];
        fall_d[i]  = ~sync_last[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign src = level_q[RST_CHANNEL];

  // Reset sequencer: a reassertion of the source always wins over stretch completion.
  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    case (state_q)
      S_RESET: begin
        if (!src) begin
          state_d = S_STRETCH;
          str_d   = '0;
        end else begin
          state_d = S_RESET;
        end
      end
      S_STRETCH: begin
        if (src) begin
          state_d = S_RESET;
        end else if (str_q == STR_LAST) begin
          state_d = S_RUN;
        end else begin
          str_d = str_q + STR_ONE;
        end
      end
      S_RUN: begin
        if (src) begin
          state_d = S_RESET;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RESET;
        str_d   = '0;
      end
    endcase
    main_rst_d = (state_d != S_RUN);
  end

  // State registers; main_rst_q mirrors the state register without a combinational decode.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level_q    <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      state_q    <= S_RESET;
      str_q      <= '0;
      main_rst_q <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      str_q      <= str_d;
      main_rst_q <= main_rst_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign main_rst_o = main_rst_q;

endmodule
